// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO over a dual-port RAM with occupancy count,
// almost-full/almost-empty thresholds, registered or fall-through read data,
// and one-cycle overflow/underflow error pulses.
module fifo_flagged #(
    parameter int depth    = 4,
    parameter int width    = 8,
    parameter int AF_LEVEL = 2**depth - 4,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [width-1:0] inputBus,
    output logic [width-1:0] outputBus,
    output logic             empty,
    output logic             full,
    output logic             almostEmpty,
    output logic             almostFull,
    output logic [depth:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int N = 2**depth;
    localparam logic [depth:0] FULL_CNT = (depth+1)'(N);
    localparam logic [depth:0] AF_CNT   = (depth+1)'(AF_LEVEL);
    localparam logic [depth:0] AE_CNT   = (depth+1)'(AE_LEVEL);
    localparam logic [depth:0] ONE_CNT  = (depth+1)'(1);
    localparam logic [depth-1:0] ONE_PTR = depth'(1);

    logic [width-1:0] mem [N];
    logic [depth-1:0] wr_ptr;
    logic [depth-1:0] rd_ptr;
    logic [depth:0]   count_r;
    logic             wr_ok;
    logic             rd_ok;

    // A full FIFO still takes a write when a read frees a slot in the same
    // cycle; an empty FIFO never satisfies a read, even alongside a write.
    assign wr_ok = write & (~full | read);
    assign rd_ok = read & ~empty;

    // Flags depend only on the registered count so they all move together.
    assign count       = count_r;
    assign empty       = (count_r == '0);
    assign full        = (count_r == FULL_CNT);
    assign almostEmpty = (count_r <= AE_CNT);
    assign almostFull  = (count_r >= AF_CNT);

    // RAM write port; contents survive reset, but requests in the reset
    // cycle must not disturb them.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= inputBus;
        end
    end

    // Pointers, occupancy and the registered error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
            overflow  <= write & ~wr_ok;
            underflow <= read & ~rd_ok;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign outputBus = mem[rd_ptr];
        end else begin : g_reg
            logic [width-1:0] out_r;

            // Registered read: capture the head word only when a read is accepted.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_r <= '0;
                end else if (rd_ok) begin
                    out_r <= mem[rd_ptr];
                end
            end

            assign outputBus = out_r;
        end
    endgenerate

endmodule

// File: doc/fifo_flagged.md
# fifo_flagged

Parametrised synchronous FIFO for the lab datapath. It generalises the basic dual-port-RAM FIFO with a selectable read mode (registered or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, and single-cycle overflow/underflow error pulses. It sits between a producer and a consumer in one clock domain and replaces the basic FIFO wherever back-pressure needs early warning.

## Interface
- depth, 4, address bits; capacity N = 2**depth entries
- width, 8, data bits per entry
- AF_LEVEL, 2**depth - 4, almostFull asserts when count >= AF_LEVEL (range 1..N)
- AE_LEVEL, 2, almostEmpty asserts when count <= AE_LEVEL (range 0..N-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- read  in  1  pop request
- write  in  1  push request
- inputBus  in  width  write data
- outputBus  out  width  read data (see Operation)
- empty  out  1  count == 0
- full  out  1  count == N
- almostEmpty  out  1  count <= AE_LEVEL
- almostFull  out  1  count >= AF_LEVEL
- count  out  depth+1  current occupancy, 0..N
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage is an N x width dual-port RAM (one write port, one read port). Read/write pointers are depth bits wide and wrap from N-1 to 0. Memory is not cleared by reset.
- Write accepted = write & (!full | read). Accepted write stores inputBus at writePtr; writePtr increments.
- Read accepted = read & !empty. An accepted read advances readPtr.
- Simultaneous read+write:
  - When full: both are accepted, count is unchanged, no overflow.
  - When empty: the write is accepted and the read is rejected (underflow pulse). count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- count += accepted write, -= accepted read. Flags are combinational functions of the count register only.
- Rejected write: overflow = 1 for the following cycle, no state change. Rejected read: underflow = 1 for the following cycle, no state change.
- FWFT=0: on an accepted read, outputBus <= mem[readPtr] at that edge. outputBus holds its value otherwise, including on a rejected read.
- FWFT=1: outputBus = mem[readPtr] continuously. It is valid whenever !empty. An accepted read exposes the next entry after the edge. Value while empty is don't-care.
- Reset has priority over read and write in the same cycle.

## Timing
- Reset values, one edge after reset = 1:
  - pointers = 0, count = 0
  - empty = 1, full = 0
  - almostEmpty = 1, almostFull = 0
  - overflow = 0, underflow = 0
  - outputBus = 0 when FWFT=0
- Write-to-visible latency:
  - FWFT=1: a word written into an empty FIFO at edge k appears on outputBus and empty = 0 after edge k.
  - FWFT=0: empty = 0 after edge k; data appears on outputBus the edge after the read is accepted.
- Flag latency: count, empty, full, almostEmpty and almostFull all change together, immediately after the edge that accepts the operation.
- overflow and underflow are registered. Each is high for exactly one cycle per rejected request, and high on consecutive cycles for consecutive rejected requests.
- Reset mid-stream: stored data is discarded logically. Requests made in the reset cycle have no effect and produce no error pulses.

## Test plan
All scenarios use the defaults (N = 16, AF_LEVEL = 12, AE_LEVEL = 2) unless stated.

- Reset check: assert reset for 1 cycle, with read and write both high during that cycle -> empty = 1, full = 0, almostEmpty = 1, count = 0, overflow = 0, underflow = 0, outputBus = 0.
- Fill and wrap:
  - Write 0x00..0x0F -> almostEmpty clears when count = 3, almostFull sets when count = 12, full sets when count = 16.
  - A 17th write -> overflow pulse, count stays 16.
  - Read all 16 -> data comes out in order 0x00..0x0F.
  - Write/read 20 more words -> correct order across the pointer wrap.
- Empty read: read with the FIFO empty -> underflow pulse for 1 cycle, count = 0, outputBus unchanged (FWFT=0).
- Simultaneous at boundaries:
  - Full, read+write 0xAA -> count stays 16, no overflow, 0xAA is the last word out.
  - Empty, read+write 0x55 -> underflow pulse, count = 1.
- FWFT=1: write 0x3C into an empty FIFO -> after the edge, outputBus = 0x3C and empty = 0 with no read. A read then gives empty = 1.
- Reset mid-stream: write 5 words, then reset -> count = 0, empty = 1. A next write of 0x11 followed by a read returns 0x11.
